// File: rtl/dbus_sram_responder_if.sv
// dbus_sram_responder_if: data-bus request/response bundle between the memory stage and its responder.
interface dbus_sram_responder_if;
    typedef logic [2:0] msize_t;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    modport master(output dreq, input dresp);
    modport slave(input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: fixed-latency 64-bit SRAM on the slave end of the data bus, one access at a time.
module dbus_sram_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    dbus_sram_responder_if.slave         bus,
    output logic                         busy,
    output logic                         proto_err
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    typedef enum logic {IDLE, WAIT} state_t;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [63:0]     lat_addr;
    logic [63:0]     lat_data;
    logic [7:0]      lat_strobe;
    logic [63:0]     mem [MEM_WORDS];
    logic [AW-1:0]   idx;
    logic            abort;
    logic            done;
    logic            unused_size;
    assign unused_size = ^bus.dreq.size;
    assign idx = lat_addr[3 +: AW];
    // Any change to the held request during WAIT cancels it, even on the data_ok cycle.
    assign abort = state == WAIT && (!bus.dreq.valid || bus.dreq.addr != lat_addr ||
                   bus.dreq.strobe != lat_strobe || bus.dreq.data != lat_data);
    assign done = state == WAIT && cnt == '0 && !abort;
    always_comb begin
        bus.dresp.addr_ok = state == IDLE && bus.dreq.valid;
        bus.dresp.data_ok = done;
        bus.dresp.data    = done && lat_strobe == '0 ? mem[idx] : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            proto_err  <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_strobe <= '0;
        end else if (state == IDLE) begin
            if (bus.dreq.valid) begin
                state      <= WAIT;
                busy       <= 1'b1;
                cnt        <= CW'(LATENCY - 1);
                lat_addr   <= bus.dreq.addr;
                lat_data   <= bus.dreq.data;
                lat_strobe <= bus.dreq.strobe;
            end
        end else if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            proto_err <= 1'b1;
        end else if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end
    // Memory is never reset; the write is still masked if reset lands on the commit edge.
    always_ff @(posedge clk) begin
        if (done && !reset)
            for (int i = 0; i < 8; i++)
                if (lat_strobe[i]) mem[idx][8*i +: 8] <= lat_data[8*i +: 8];
    end
endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb_dbus_sram_responder: two responders (latency 2 and 3) checked against a transaction-level timing model.
module tb_dbus_sram_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rq_v [2] = '{1'b0, 1'b0};
    logic [63:0] rq_a [2] = '{64'd0, 64'd0};
    logic [63:0] rq_d [2] = '{64'd0, 64'd0};
    logic [7:0]  rq_s [2] = '{8'd0, 8'd0};
    logic        aok [2], dok [2], bsy [2], perr [2];
    logic [63:0] rdat [2];

    dbus_sram_responder_if b0();
    dbus_sram_responder_if b1();
    assign b0.dreq = '{valid: rq_v[0], addr: rq_a[0], size: 3'd3, strobe: rq_s[0], data: rq_d[0]};
    assign b1.dreq = '{valid: rq_v[1], addr: rq_a[1], size: 3'd3, strobe: rq_s[1], data: rq_d[1]};
    assign aok[0] = b0.dresp.addr_ok;
    assign dok[0] = b0.dresp.data_ok;
    assign rdat[0] = b0.dresp.data;
    assign aok[1] = b1.dresp.addr_ok;
    assign dok[1] = b1.dresp.data_ok;
    assign rdat[1] = b1.dresp.data;

    dbus_sram_responder #(.MEM_WORDS(1024), .LATENCY(2)) u0 (
        .clk(clk), .reset(reset), .bus(b0), .busy(bsy[0]), .proto_err(perr[0]));
    dbus_sram_responder #(.MEM_WORDS(1024), .LATENCY(3)) u1 (
        .clk(clk), .reset(reset), .bus(b1), .busy(bsy[1]), .proto_err(perr[1]));

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h expected=%h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Model: a request accepted in cycle c completes in cycle c+latency unless it is disturbed first.
    bit          pend [2] = '{1'b0, 1'b0};
    bit          err [2] = '{1'b0, 1'b0};
    int          tdone [2];
    logic [63:0] qa [2], qd [2];
    logic [7:0]  qs [2];
    logic [63:0] mm [2][1024];
    bit          known [2][1024];
    int          cyc = 0;

    function automatic bit changed(input int k);
        return pend[k] && (!rq_v[k] || rq_a[k] !== qa[k] || rq_s[k] !== qs[k] || rq_d[k] !== qd[k]);
    endfunction
    function automatic bit due(input int k);
        return pend[k] && !changed(k) && cyc == tdone[k];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                pend[k] = 1'b0;
                err[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (pend[k]) begin
                    if (changed(k)) begin
                        pend[k] = 1'b0;
                        err[k] = 1'b1;
                    end else if (cyc == tdone[k]) begin
                        for (int b = 0; b < 8; b++)
                            if (qs[k][b]) mm[k][qa[k][12:3]][8*b +: 8] = qd[k][8*b +: 8];
                        if (qs[k] == 8'hFF) known[k][qa[k][12:3]] = 1'b1;
                        pend[k] = 1'b0;
                    end
                end else if (rq_v[k]) begin
                    pend[k] = 1'b1;
                    tdone[k] = cyc + (k == 1 ? 3 : 2);
                    qa[k] = rq_a[k];
                    qs[k] = rq_s[k];
                    qd[k] = rq_d[k];
                end
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit          ed;
            logic [63:0] edat;
            ed = due(k);
            edat = (ed && qs[k] == 8'd0) ? mm[k][qa[k][12:3]] : 64'd0;
            chk("addr_ok", k, 64'(aok[k]), 64'(!pend[k] && rq_v[k]));
            chk("data_ok", k, 64'(dok[k]), 64'(ed));
            chk("busy", k, 64'(bsy[k]), 64'(pend[k]));
            chk("proto_err", k, 64'(perr[k]), 64'(err[k]));
            if (!(ed && qs[k] == 8'd0 && !known[k][qa[k][12:3]]))
                chk("rdata", k, rdat[k], edat);
        end
    end

    // Caller starts just after a rising edge; n counts cycles from acceptance to data_ok.
    task automatic xact(input int k, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                        output logic [63:0] rd, output int n);
        rq_v[k] = 1'b1;
        rq_a[k] = a;
        rq_s[k] = s;
        rq_d[k] = d;
        rd = 'x;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (dok[k]) begin
                rd = rdat[k];
                break;
            end
            n++;
        end
        @(posedge clk);
        #1 rq_v[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] rd;
        logic [63:0] rv [2];
        int          n;
        int          dk [2];
        int          nd;
        int          low;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 0, 64'(bsy[0]), 64'd0);
        chk("rst_perr", 0, 64'(perr[0]), 64'd0);
        chk("rst_data_ok", 0, 64'(dok[0]), 64'd0);
        @(posedge clk);
        #1;
        xact(0, 64'h80, 8'hFF, 64'h1122334455667788, rd, n);
        chk("t1_store_lat", 0, 64'(n), 64'd2);
        xact(0, 64'h80, 8'h00, 64'd0, rd, n);
        chk("t1_load_lat", 0, 64'(n), 64'd2);
        chk("t1_load_data", 0, rd, 64'h1122334455667788);
        xact(0, 64'h80, 8'h0F, 64'hFFFFFFFF_AABBCCDD, rd, n);
        xact(0, 64'h80, 8'h00, 64'd0, rd, n);
        chk("t2_partial", 0, rd, 64'h11223344AABBCCDD);
        xact(0, 64'h2080, 8'hFF, 64'hDEADBEEF0BADF00D, rd, n);
        xact(0, 64'h80, 8'h00, 64'd0, rd, n);
        chk("t3_alias", 0, rd, 64'hDEADBEEF0BADF00D);

        xact(1, 64'h40, 8'hFF, 64'hA5A5A5A5_01020304, rd, n);
        chk("t4_store_lat", 1, 64'(n), 64'd3);
        xact(1, 64'h48, 8'hFF, 64'h5A5A5A5A_0A0B0C0D, rd, n);
        rq_v[1] = 1'b1;
        rq_a[1] = 64'h40;
        rq_s[1] = 8'h00;
        rq_d[1] = 64'd0;
        nd = 0;
        low = 0;
        for (int i = 0; i < 16 && nd < 2; i++) begin
            @(negedge clk);
            if (nd == 1 && !bsy[1]) low++;
            if (dok[1]) begin
                rv[nd] = rdat[1];
                dk[nd] = i;
                nd++;
                @(posedge clk);
                #1;
                if (nd == 1) rq_a[1] = 64'h48;
                else rq_v[1] = 1'b0;
            end
        end
        @(posedge clk);
        #1 rq_v[1] = 1'b0;
        chk("t4_pulses", 1, 64'(nd), 64'd2);
        chk("t4_gap", 1, 64'(dk[1] - dk[0]), 64'd4);
        chk("t4_busy_low", 1, 64'(low), 64'd1);
        chk("t4_data0", 1, rv[0], 64'hA5A5A5A5_01020304);
        chk("t4_data1", 1, rv[1], 64'h5A5A5A5A_0A0B0C0D);

        rq_v[0] = 1'b1;
        rq_a[0] = 64'h80;
        rq_s[0] = 8'hFF;
        rq_d[0] = 64'h5555555555555555;
        @(negedge clk);
        chk("t5_accept", 0, 64'(aok[0]), 64'd1);
        @(posedge clk);
        #1 rq_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_perr_set", 0, 64'(perr[0]), 64'd1);
        @(posedge clk);
        #1;
        xact(0, 64'h80, 8'h00, 64'd0, rd, n);
        chk("t5_unchanged", 0, rd, 64'hDEADBEEF0BADF00D);
        @(negedge clk);
        chk("t5_perr_sticky", 0, 64'(perr[0]), 64'd1);
        @(posedge clk);
        #1;

        rq_v[0] = 1'b1;
        rq_a[0] = 64'h80;
        rq_s[0] = 8'hFF;
        rq_d[0] = 64'h0123456789ABCDEF;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (dok[0]) break;
            n++;
        end
        chk("t6_lat", 0, 64'(n), 64'd2);
        #1 reset = 1'b1;
        #1;
        chk("t6_busy", 0, 64'(bsy[0]), 64'd0);
        rq_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_perr", 0, 64'(perr[0]), 64'd0);
        @(posedge clk);
        #1;
        xact(0, 64'h80, 8'h00, 64'd0, rd, n);
        chk("t6_unchanged", 0, rd, 64'hDEADBEEF0BADF00D);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
